// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame decoder: FSM states, the sync byte,
// default sizing and a small address-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CKSUM   = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    localparam logic [7:0] SYNC_BYTE             = 8'hA5;
    localparam int         DEFAULT_MAX_LEN       = 16;
    localparam int         DEFAULT_TIMEOUT_TICKS = 160;

    // Buffer address width; never below one bit so a single-entry buffer still has a port.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Payload output stream of the UART frame decoder.
// Handshake: a byte transfers on every rising edge where out_valid && out_ready; while
// out_valid=1 and out_ready=0 the producer holds out_data/out_last unchanged, and
// out_valid never drops without a transfer. out_last marks the final byte of a frame.
interface uart_frame_decoder_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer for the frame decoder: DEPTH x 8 register file with one synchronous
// write port and one combinational read port.
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_LEN,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/LEN/payload/CKSUM frames from a byte receiver and streams the payload out.
// Optional inter-byte timeout is built in when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_decoder
    import uart_pkg::*;
#(
    parameter int MAX_LEN       = DEFAULT_MAX_LEN,
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        baud_tick,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_done,
    uart_frame_decoder_if.master        stream,
    output logic                        frame_ok,
    output logic                        err_len,
    output logic                        err_cksum,
    output logic                        err_ovr,
    output logic                        err_timeout,
    output state_t                      dbg_state
);

    localparam int         AW        = addr_width(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state, state_n;
    logic [7:0] len, len_n;
    logic [7:0] idx, idx_n;
    logic [7:0] cksum, cksum_n;
    logic [7:0] data, data_n;
    logic       valid, valid_n;
    logic       last, last_n;
    logic       ok_n, elen_n, eck_n, eovr_n;
    logic       wr_en;
    logic [AW-1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] idx_inc;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] tcnt, tcnt_n;
    logic          eto_n;
`else
    logic unused_tick;
    assign unused_tick = baud_tick;
    assign err_timeout = 1'b0;
`endif

    assign idx_inc = idx + 8'd1;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (idx[AW-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n = state;
        len_n   = len;
        idx_n   = idx;
        cksum_n = cksum;
        data_n  = data;
        valid_n = valid;
        last_n  = last;
        ok_n    = 1'b0;
        elen_n  = 1'b0;
        eck_n   = 1'b0;
        eovr_n  = 1'b0;
        wr_en   = 1'b0;
        rd_addr = '0;
`ifdef UART_FRAME_TIMEOUT_EN
        tcnt_n  = tcnt;
        eto_n   = 1'b0;
`endif
        unique case (state)
            ST_HUNT: begin
                if (rx_done && rx_data == SYNC_BYTE) begin
                    state_n = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_done) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        elen_n  = 1'b1;
                        state_n = ST_HUNT;
                    end else begin
                        len_n   = rx_data;
                        cksum_n = rx_data;
                        idx_n   = 8'd0;
                        state_n = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_done) begin
                    wr_en   = 1'b1;
                    cksum_n = cksum ^ rx_data;
                    idx_n   = idx_inc;
                    if (idx == len - 8'd1) begin
                        state_n = ST_CKSUM;
                    end
                end
            end
            ST_CKSUM: begin
                if (rx_done) begin
                    if (rx_data == cksum) begin
                        ok_n    = 1'b1;
                        valid_n = 1'b1;
                        data_n  = rd_data;
                        last_n  = (len == 8'd1);
                        idx_n   = 8'd0;
                        state_n = ST_OUTPUT;
                    end else begin
                        eck_n   = 1'b1;
                        state_n = ST_HUNT;
                    end
                end
            end
            ST_OUTPUT: begin
                // Read ahead so the next byte is ready the moment the current one is taken.
                rd_addr = idx_inc[AW-1:0];
                if (rx_done) begin
                    eovr_n = 1'b1;
                end
                if (valid && stream.out_ready) begin
                    if (last) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        idx_n   = 8'd0;
                        state_n = ST_HUNT;
                    end else begin
                        data_n = rd_data;
                        idx_n  = idx_inc;
                        last_n = (idx_inc == len - 8'd1);
                    end
                end
            end
            default: begin
                state_n = ST_HUNT;
            end
        endcase
`ifdef UART_FRAME_TIMEOUT_EN
        // A byte arriving on the final tick restarts the count instead of timing out.
        if (state == ST_LEN || state == ST_PAYLOAD || state == ST_CKSUM) begin
            if (rx_done) begin
                tcnt_n = '0;
            end else if (baud_tick) begin
                if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
                    tcnt_n  = '0;
                    eto_n   = 1'b1;
                    state_n = ST_HUNT;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
        end else begin
            tcnt_n = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HUNT;
            len       <= 8'd0;
            idx       <= 8'd0;
            cksum     <= 8'd0;
            data      <= 8'd0;
            valid     <= 1'b0;
            last      <= 1'b0;
            frame_ok  <= 1'b0;
            err_len   <= 1'b0;
            err_cksum <= 1'b0;
            err_ovr   <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            idx       <= idx_n;
            cksum     <= cksum_n;
            data      <= data_n;
            valid     <= valid_n;
            last      <= last_n;
            frame_ok  <= ok_n;
            err_len   <= elen_n;
            err_cksum <= eck_n;
            err_ovr   <= eovr_n;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            tcnt        <= tcnt_n;
            err_timeout <= eto_n;
        end
    end
`endif

    assign stream.out_data  = data;
    assign stream.out_valid = valid;
    assign stream.out_last  = last;
    assign dbg_state        = state;

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning maximum payload bytes per frame (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 160, meaning inter-byte timeout in baud_tick pulses.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_tick  input  1  one-cycle baud-rate strobe, shared with the receiver.
REQ-006 SHALL have port rx_data  input  8  received byte, valid when rx_done=1.
REQ-007 SHALL have port rx_done  input  1  one-cycle strobe marking a new received byte.
REQ-008 SHALL have port out_data  output  8  payload byte.
REQ-009 SHALL have port out_valid  output  1  out_data is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the byte.
REQ-011 SHALL have port out_last  output  1  current out_data is the final payload byte.
REQ-012 SHALL have ports frame_ok, err_len, err_cksum, err_ovr, err_timeout  output  1 each  one-cycle status pulses.

Function
REQ-013 SHALL parse frames as SYNC (0xA5), LEN, LEN payload bytes, CKSUM, where CKSUM = XOR of LEN and all payload bytes.
REQ-014 SHALL implement states HUNT, LEN, PAYLOAD, CKSUM, OUTPUT; HUNT ignores every byte except 0xA5, which moves it to LEN.
REQ-015 SHALL, in LEN, go to HUNT with err_len pulsed next cycle if LEN=0 or LEN>MAX_LEN; otherwise store LEN, seed the running XOR with LEN, and go to PAYLOAD.
REQ-016 SHALL, in PAYLOAD, write each byte to buffer index 0..LEN-1 and XOR it into the running checksum; after byte LEN-1 go to CKSUM.
REQ-017 SHALL, in CKSUM on a match, go to OUTPUT, assert frame_ok for exactly one cycle, and assert out_valid with buffer[0], both in the cycle after the rx_done.
REQ-018 SHALL, in CKSUM on a mismatch, pulse err_cksum the next cycle and return to HUNT with no out_valid.
REQ-019 SHALL hold out_data/out_valid/out_last stable while out_valid=1 and out_ready=0; advance the index on out_valid&&out_ready.
REQ-020 SHALL assert out_last only with the byte at index LEN-1; its handshake returns the FSM to HUNT on the same edge, and out_valid is 0 the next cycle.
REQ-021 SHALL drop any rx_done arriving in OUTPUT and pulse err_ovr the next cycle; the in-progress output frame is not disturbed.
REQ-022 SHALL keep all err_* and frame_ok deasserted except for their single-cycle pulses; at most one error pulses per cycle.
REQ-023 SHALL treat 0xA5 arriving in LEN/PAYLOAD/CKSUM as ordinary data, with no resynchronisation.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter HUNT and clear out_data=0x00, out_valid=0, out_last=0, all status pulses=0, the index, the checksum and the timeout counter.
REQ-025 SHALL abandon a frame that is in progress mid-operation when reset is asserted, without emitting frame_ok or any error pulse; buffer contents need not be cleared.

Configuration
REQ-026 SHALL, with UART_FRAME_TIMEOUT_EN defined, count baud_tick pulses in LEN/PAYLOAD/CKSUM, clearing the count on each rx_done.
REQ-027 SHALL, in that build, when the count reaches TIMEOUT_TICKS, return to HUNT and pulse err_timeout the next cycle; if rx_done coincides with the final tick, rx_done wins and the timeout does not fire.
REQ-028 SHALL, without UART_FRAME_TIMEOUT_EN, omit the counter, hold err_timeout constant 0, and wait indefinitely for bytes.

Structure
REQ-029 SHALL place the FSM state enum, SYNC_BYTE=8'hA5 and the default MAX_LEN/TIMEOUT_TICKS constants in shared package uart_pkg.
REQ-030 SHALL implement the payload storage as sub-module uart_frame_buf: MAX_LEN x 8 register file, one synchronous write port and one combinational read port.

Verification
REQ-031 SHALL cover: bytes A5 03 11 22 33 03 -> frame_ok pulse; out_data 11,22,33 with out_last on 33; no errors.
REQ-032 SHALL cover: the same frame with CKSUM=04 -> err_cksum pulse, out_valid never asserted, next valid frame decoded.
REQ-033 SHALL cover: A5 00, and A5 11 with MAX_LEN=16 -> err_len pulse each time, return to HUNT.
REQ-034 SHALL cover: a valid frame with out_ready=0 for 20 cycles while byte 0x55 arrives -> err_ovr pulse; out_data held at 11; full payload delivered after out_ready=1.
REQ-035 SHALL cover: with UART_FRAME_TIMEOUT_EN defined, A5 03 11 then 160 idle baud_ticks -> err_timeout pulse, HUNT; rst asserted mid-PAYLOAD -> all outputs 0, no pulses.
